// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, field positions, FSM encoding and opcode constants for the fetch unit
package fetch_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 16;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RS_HI = 11;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 7;
  localparam int TGT_LO = 0;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1101;
  localparam logic [3:0] OP_BNE = 4'b1110;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ISSUE = 2'd2} state_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC select (jump target, pc+1+sext(imm), or pc+1), modulo 256
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] ir,
  input  logic               jump,
  input  logic               branch,
  output logic [PC_W-1:0]    pc_next
);
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] off;
  logic unused;
  assign unused = ^{ir[OP_HI:OP_LO], ir[RS_HI:RS_LO]};
  always_comb begin
    seq = pc + PC_W'(1);
    off = {{(PC_W-4){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    pc_next = jump ? ir[TGT_HI:TGT_LO] : branch ? seq + off : seq;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/REQ/ISSUE instruction fetch with PC sequencing; FETCH_ICOUNT_EN adds icount port
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic               instr_valid,
  input  logic               jump,
  input  logic               branch,
  input  logic               stall,
`ifdef FETCH_ICOUNT_EN
  output logic [15:0]        icount,
`endif
  output logic [PC_W-1:0]    pc
);
  state_t state, state_next;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0] pc_next;
  logic advance;
  pc_next_calc u_pc_next_calc (
    .pc(pc),
    .ir(ir),
    .jump(jump),
    .branch(branch),
    .pc_next(pc_next)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? REQ
               : state == REQ ? (imem_ack ? ISSUE : REQ)
               : state == ISSUE ? (stall ? ISSUE : REQ)
               : IDLE;
  end
  always_comb begin
    imem_req = state == REQ;
    instr_valid = state == ISSUE;
    advance = instr_valid && !stall;
    imem_addr = pc;
    instr = ir;
    op = ir[OP_HI:OP_LO];
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (imem_req && imem_ack) ir <= imem_rdata;
      if (advance) pc <= pc_next;
    end
`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge clk)
    if (rst) icount <= '0;
    else if (advance) icount <= icount + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a per-cycle phase/PC model and literal spot checks
module tb_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  logic imem_req;
  logic [7:0] imem_addr;
  logic imem_ack = 0;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [15:0] instr;
  logic [3:0] op;
  logic instr_valid;
  logic jump = 0;
  logic branch = 0;
  logic stall = 0;
  logic [7:0] pc;
`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount;
`endif
  int checks = 0;
  int failures = 0;
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .op(op),
    .instr_valid(instr_valid),
    .jump(jump),
    .branch(branch),
    .stall(stall),
`ifdef FETCH_ICOUNT_EN
    .icount(icount),
`endif
    .pc(pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int next_pc(int p, logic [15:0] w, logic j, logic b);
    int imm = int'(w[3:0]);
    if (imm > 7) imm -= 16;
    if (j) return int'(w[7:0]);
    if (b) return (p + 1 + imm + 256) % 256;
    return (p + 1) % 256;
  endfunction
  int m_phase = 0;
  int m_pc = 0;
  logic [15:0] m_ir = 0;
  logic [15:0] m_ic = 0;
  logic started = 0;
  logic ic_ok = 1;
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_pc <= 0;
      m_ir <= 0;
      m_ic <= 0;
      started <= 1;
    end else if (m_phase == 0) m_phase <= 1;
    else if (m_phase == 1) begin
      if (imem_ack) begin
        m_ir <= imem_rdata;
        m_phase <= 2;
      end
    end else if (!stall) begin
      m_pc <= next_pc(m_pc, m_ir, jump, branch);
      m_ic <= m_ic + 16'd1;
      m_phase <= 1;
    end
  end
  always @(negedge clk)
    if (started) begin
      chk("imem_req", imem_req, m_phase == 1);
      chk("instr_valid", instr_valid, m_phase == 2);
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instr, m_ir);
      chk("op", op, m_ir >> 12);
`ifdef FETCH_ICOUNT_EN
      if (ic_ok) chk("icount", icount, m_ic);
`endif
    end
  logic meas = 0;
  int req_cnt = 0;
  int val_cnt = 0;
  always @(negedge clk)
    if (meas) begin
      req_cnt <= req_cnt + int'(imem_req);
      val_cnt <= val_cnt + int'(instr_valid);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    chk("wait_req", imem_req, 1);
  endtask
  task automatic ack_after(input logic [15:0] w, input int d);
    wait_req();
    repeat (d) step();
    imem_rdata = w;
    imem_ack = 1;
    step();
    imem_ack = 0;
    imem_rdata = 16'hDEAD;
  endtask
  task automatic issue(input logic j, input logic b, input int s);
    logic [7:0] p0 = pc;
    jump = j;
    branch = b;
    stall = s > 0;
    for (int k = 0; k < s; k++) begin
      step();
      chk("stall_pc", pc, p0);
      chk("stall_valid", instr_valid, 1);
    end
    stall = 0;
    step();
    jump = 0;
    branch = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    step();
    rst = 0;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      chk("seq_addr", imem_addr, i);
      ack_after(16'h2123, 0);
      chk("seq_op", op, 2);
      issue(0, 0, 0);
    end
    ack_after(16'h70A5, 0);
    issue(1, 1, 0);
    wait_req();
    chk("jump_prio_addr", imem_addr, 8'hA5);
    ack_after(16'h7010, 0);
    issue(1, 0, 0);
    chk("jump_pc", pc, 8'h10);
    ack_after(16'hD01E, 0);
    issue(0, 1, 0);
    chk("branch_back", pc, 8'h0F);
    ack_after(16'h7010, 0);
    issue(1, 0, 0);
    ack_after(16'hD01E, 0);
    issue(0, 0, 0);
    chk("not_taken", pc, 8'h11);
    ack_after(16'h70FF, 0);
    issue(1, 0, 0);
    chk("jump_ff", pc, 8'hFF);
    ack_after(16'h1234, 0);
    issue(0, 0, 0);
    chk("wrap_up", pc, 8'h00);
    ack_after(16'hD008, 0);
    issue(0, 1, 0);
    chk("wrap_down", pc, 8'hF9);
    ack_after(16'hE003, 0);
    issue(0, 1, 0);
    chk("branch_fwd", pc, 8'hFD);
    wait_req();
    meas = 1;
    ack_after(16'h3456, 5);
    issue(0, 0, 3);
    meas = 0;
    chk("req_cycles", req_cnt, 6);
    chk("valid_cycles", val_cnt, 4);
    chk("stall_done_pc", pc, 8'hFE);
    wait_req();
    rst = 1;
    step();
    rst = 0;
    imem_rdata = 16'hBEEF;
    imem_ack = 1;
    chk("abort_req", imem_req, 0);
    chk("abort_pc", pc, 0);
    step();
    imem_ack = 0;
    chk("abort_instr", instr, 0);
    chk("abort_req2", imem_req, 1);
    chk("abort_addr", imem_addr, 0);
`ifdef FETCH_ICOUNT_EN
    ack_after(16'h0000, 0);
    ic_ok = 0;
    force dut.icount = 16'hFFFF;
    #1;
    release dut.icount;
    stall = 1;
    step();
    chk("icount_stall", icount, 16'hFFFF);
    stall = 0;
    step();
    chk("icount_wrap", icount, 16'h0000);
`endif
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 Port `clk`  in  1  rising-edge clock.
REQ-003 Port `rst`  in  1  synchronous active-high reset.
REQ-004 Port `imem_req`  out  1  instruction-memory read request, level, held until ack.
REQ-005 Port `imem_addr`  out  8  word address of request (equals `pc`).
REQ-006 Port `imem_ack`  in  1  read data valid this cycle; one-cycle pulse.
REQ-007 Port `imem_rdata`  in  16  instruction word.
REQ-008 Port `instr`  out  16  issued instruction register `ir`.
REQ-009 Port `op`  out  4  `ir[15:12]`, drives control-unit opcode input.
REQ-010 Port `instr_valid`  out  1  high in ISSUE state.
REQ-011 Port `jump`  in  1  from control unit; sampled only in ISSUE.
REQ-012 Port `branch`  in  1  from control unit (already zero-qualified); sampled only in ISSUE.
REQ-013 Port `stall`  in  1  datapath hold request; holds ISSUE.
REQ-014 Port `pc`  out  8  current program counter.

Function
REQ-015 Instruction fields SHALL be: op `[15:12]`, rs `[11:8]`, rt `[7:4]`, imm `[3:0]`; jump target `[7:0]`.
REQ-016 The FSM SHALL have states IDLE, REQ, ISSUE; reset enters IDLE.
REQ-017 IDLE SHALL last exactly one cycle, then go to REQ; `imem_req`=0 in IDLE.
REQ-018 In REQ: `imem_req`=1, `imem_addr`=`pc`; on `imem_ack`=1 latch `imem_rdata` into `ir` and go to ISSUE next cycle; otherwise stay in REQ indefinitely.
REQ-019 `imem_req` SHALL be combinationally 0 in the cycle after ack (state ISSUE); ack in IDLE/ISSUE SHALL be ignored.
REQ-020 In ISSUE: `instr_valid`=1; if `stall`=1, hold state, `pc`, `ir`.
REQ-021 In ISSUE with `stall`=0, next `pc` SHALL be: `jump` -> `ir[7:0]`; else `branch` -> `pc`+1+sign-extend(`ir[3:0]`); else `pc`+1; then go to REQ.
REQ-022 `jump` SHALL take priority when `jump` and `branch` are both 1.
REQ-023 All `pc` arithmetic SHALL be modulo 256 (0xFF+1 -> 0x00; 0x00+1-8 -> 0xF9).
REQ-024 Minimum fetch-to-fetch period SHALL be 2 cycles (REQ with immediate ack, ISSUE unstalled).

Reset
REQ-025 On `rst`=1 at a clock edge: state=IDLE, `pc`=0, `ir`=0 (so `op`=0), `instr_valid`=0, `imem_req`=0, regardless of current state.
REQ-026 Reset during an outstanding REQ SHALL abandon it; a later ack SHALL NOT load `ir`.

Configuration
REQ-027 With `FETCH_ICOUNT_EN` defined: add port `icount` (out, 16 bits), reset to 0, incremented on every unstalled ISSUE cycle, wrapping 0xFFFF -> 0x0000.
REQ-028 Without `FETCH_ICOUNT_EN`, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package `fetch_pkg` SHALL hold PC/instruction widths, field bit positions, state encoding, and opcode constants (JMP=0111, BEQ=1101, BNE=1110).
REQ-030 Next-PC selection SHALL be a combinational sub-module `pc_next_calc` (inputs: `pc`, `ir`, `jump`, `branch`; output: next `pc`).

Verification
REQ-031 Reset, ack the same cycle as each request, `rdata`=0x2123 -> addresses 0,1,2 on successive REQ cycles, `op`=2 in each ISSUE.
REQ-032 `ir`=0x70A5, `jump`=1, `branch`=1 in ISSUE -> next `imem_addr`=0xA5.
REQ-033 `pc`=0x10, `ir`=0xD01E, `branch`=1 -> next `pc`=0x0F; with `branch`=0 -> 0x11; `pc`=0xFF unbranched -> 0x00.
REQ-034 Hold `imem_ack` low 5 cycles, then `stall`=1 for 3 cycles in ISSUE -> `imem_req` high 6 cycles, `instr_valid` high 4 cycles, `pc` unchanged while stalled.
REQ-035 Assert `rst` mid-REQ, then ack 1 cycle after reset -> `ir`=0, `pc`=0, IDLE then REQ to address 0.
REQ-036 With `FETCH_ICOUNT_EN`, preload `icount` to 0xFFFF (force) and perform one unstalled issue -> `icount`=0x0000; a stalled ISSUE -> no increment.
